// File: rtl/vector_dmem_responder_if.sv
// vector_dmem_responder_if: request/response bundle between the vector LSU data port and its memory responder
// master drives ren/wen/addr/storedata/byte_ena; slave drives dhit/loaddata/addr_fault/protocol_err/busy
interface vector_dmem_responder_if;
  logic ren;
  logic wen;
  logic [31:0] addr;
  logic [31:0] storedata;
  logic [3:0] byte_ena;
  logic dhit;
  logic [31:0] loaddata;
  logic addr_fault;
  logic protocol_err;
  logic busy;
  modport master(output ren, wen, addr, storedata, byte_ena, input dhit, loaddata, addr_fault, protocol_err, busy);
  modport slave(input ren, wen, addr, storedata, byte_ena, output dhit, loaddata, addr_fault, protocol_err, busy);
endinterface

// File: rtl/vector_dmem_responder.sv
// vector_dmem_responder: fixed-latency word scratchpad answering the vector unit's scalarized data requests
// Ports: CLK rising edge; RST async active-high; bus (slave) takes ren/wen/addr/storedata/byte_ena and
// returns a one-cycle dhit with loaddata/addr_fault, plus protocol_err pulses and busy while WAIT/RESP
module vector_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic CLK,
  input logic RST,
  vector_dmem_responder_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic l_ren, l_wen;
  logic [31:0] l_addr, l_data;
  logic [3:0] l_be;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle, req, req_w, in_rng, fire;
  logic [31:0] req_addr, off, rdata;
  logic [3:0] req_be;
  logic [IW-1:0] idx;
  // In IDLE the live request is decoded so LATENCY=1 can respond straight from acceptance;
  // afterwards only the latched request matters.
  always_comb begin
    idle = state == IDLE;
    req = bus.ren | bus.wen;
    req_addr = idle ? bus.addr : l_addr;
    req_be = idle ? bus.byte_ena : l_be;
    req_w = idle ? bus.wen : l_wen;
    off = req_addr - BASE_ADDR;
    idx = off[IW+1:2];
    in_rng = req_addr >= BASE_ADDR && off < SPAN;
    fire = req && (idle ? LATENCY == 1 : state == WAIT && cnt == 4'd1);
    rdata = '0;
    for (int i = 0; i < 4; i++) rdata[8*i+:8] = req_be[i] && in_rng && !req_w ? mem[idx][8*i+:8] : 8'h00;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      l_ren <= 1'b0;
      l_wen <= 1'b0;
      l_addr <= '0;
      l_data <= '0;
      l_be <= '0;
      bus.dhit <= 1'b0;
      bus.loaddata <= '0;
      bus.addr_fault <= 1'b0;
      bus.protocol_err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.dhit <= 1'b0;
      bus.loaddata <= '0;
      bus.addr_fault <= 1'b0;
      bus.protocol_err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          l_ren <= bus.ren;
          l_wen <= bus.wen;
          l_addr <= bus.addr;
          l_data <= bus.storedata;
          l_be <= bus.byte_ena;
          cnt <= 4'(LATENCY - 1);
          bus.protocol_err <= bus.ren & bus.wen;
          bus.busy <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (!req) begin
          state <= IDLE;
          cnt <= '0;
          bus.busy <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
          bus.protocol_err <= {bus.ren, bus.wen, bus.addr, bus.byte_ena} != {l_ren, l_wen, l_addr, l_be};
        end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
      // Completion overrides the WAIT transition chosen above.
      if (fire) begin
        state <= RESP;
        bus.dhit <= 1'b1;
        bus.addr_fault <= !in_rng;
        bus.loaddata <= rdata;
      end
    end
  // Writes commit at the edge ending RESP, so a reset during WAIT drops them.
  always_ff @(posedge CLK)
    if (state == RESP && l_wen && in_rng)
      for (int i = 0; i < 4; i++) if (l_be[i]) mem[idx][8*i+:8] <= l_data[8*i+:8];
endmodule

// File: tb/tb_vector_dmem_responder.sv
// tb_vector_dmem_responder: scoreboard bench for vector_dmem_responder at LATENCY=2 and LATENCY=1
module tb_vector_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  vector_dmem_responder_if bus();
  vector_dmem_responder_if bus1();
  vector_dmem_responder dut (.CLK(clk), .RST(rst), .bus(bus));
  vector_dmem_responder #(.LATENCY(1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));
  typedef struct {int cyc; logic [31:0] ld; logic f;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int hc;
  logic [31:0] ld;
  logic f, pe, after, b1, b2, seen;

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.ren = r; bus.wen = w; bus.addr = a; bus.storedata = d; bus.byte_ena = be;
    hc = -1; ld = '0; f = 1'b0; pe = 1'b0;
    for (int c = 1; c <= 12 && hc < 0; c++) begin
      @(negedge clk);
      pe |= bus.protocol_err;
      if (bus.dhit) begin
        hc = c; ld = bus.loaddata; f = bus.addr_fault;
        bus.ren = 1'b0; bus.wen = 1'b0;
      end
    end
    bus.ren = 1'b0; bus.wen = 1'b0;
    @(negedge clk);
    after = bus.dhit;
    pe |= bus.protocol_err;
  endtask

  task automatic test_reset;
    bus.ren = 0; bus.wen = 0; bus.addr = 0; bus.storedata = 0; bus.byte_ena = 0;
    bus1.ren = 0; bus1.wen = 0; bus1.addr = 0; bus1.storedata = 0; bus1.byte_ena = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.dhit, bus.loaddata, bus.addr_fault, bus.protocol_err, bus.busy} !== 36'h0) begin
      errors++; $display("FAIL reset_lat2 got dhit=%b ld=%h f=%b pe=%b busy=%b want all 0", bus.dhit, bus.loaddata, bus.addr_fault, bus.protocol_err, bus.busy);
    end
    checks++;
    if ({bus1.dhit, bus1.loaddata, bus1.addr_fault, bus1.protocol_err, bus1.busy} !== 36'h0) begin
      errors++; $display("FAIL reset_lat1 got dhit=%b ld=%h f=%b pe=%b busy=%b want all 0", bus1.dhit, bus1.loaddata, bus1.addr_fault, bus1.protocol_err, bus1.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    sb.push_back('{2, 32'h0, 1'b0});
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f || after !== 1'b0 || pe !== 1'b0) begin
      errors++; $display("FAIL full_write got cyc=%0d ld=%h f=%b after=%b pe=%b want cyc=%0d ld=%h f=%b after=0 pe=0", hc, ld, f, after, pe, e.cyc, e.ld, e.f);
    end
    sb.push_back('{2, 32'hDEADBEEF, 1'b0});
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL full_read got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
  endtask

  task automatic test_partial;
    sb.push_back('{2, 32'h0, 1'b0});
    sb.push_back('{2, 32'hDE22BE44, 1'b0});
    sb.push_back('{2, 32'hDE000000, 1'b0});
    access(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL partial_write got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL partial_readback got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'b1000);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL lane_mask_read got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
  endtask

  task automatic test_range;
    sb.push_back('{2, 32'h0, 1'b1});
    sb.push_back('{2, 32'h0, 1'b0});
    sb.push_back('{2, 32'h0, 1'b1});
    sb.push_back('{2, 32'hA5A5A5A5, 1'b0});
    access(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL oob_read got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
    access(1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL last_word_write got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
    access(1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL oob_write got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
    access(1'b1, 1'b0, 32'h3FC, 32'h0, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL last_word_intact got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
  endtask

  task automatic test_both_high;
    sb.push_back('{2, 32'h0, 1'b0});
    sb.push_back('{2, 32'hCAFEF00D, 1'b0});
    access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f || pe !== 1'b1) begin
      errors++; $display("FAIL both_high got cyc=%0d ld=%h f=%b pe=%b want cyc=%0d ld=%h f=%b pe=1", hc, ld, f, pe, e.cyc, e.ld, e.f);
    end
    access(1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f || pe !== 1'b0) begin
      errors++; $display("FAIL both_high_readback got cyc=%0d ld=%h f=%b pe=%b want cyc=%0d ld=%h f=%b pe=0", hc, ld, f, pe, e.cyc, e.ld, e.f);
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    bus.ren = 1'b1; bus.wen = 1'b0; bus.addr = 32'h10; bus.byte_ena = 4'hF;
    @(negedge clk);
    b1 = bus.busy;
    bus.ren = 1'b0;
    @(negedge clk);
    b2 = bus.busy;
    seen = 1'b0;
    repeat (4) begin
      seen |= bus.dhit | bus.protocol_err;
      @(negedge clk);
    end
    checks++;
    if (b1 !== 1'b1 || b2 !== 1'b0 || seen !== 1'b0) begin
      errors++; $display("FAIL abort got busy_wait=%b busy_after=%b dhit_or_perr=%b want 1 0 0", b1, b2, seen);
    end
  endtask

  task automatic test_protocol;
    sb.push_back('{2, 32'hDE22BE44, 1'b0});
    @(negedge clk);
    bus.ren = 1'b1; bus.wen = 1'b0; bus.addr = 32'h10; bus.byte_ena = 4'hF;
    @(negedge clk);
    bus.addr = 32'h400;
    @(negedge clk);
    b1 = bus.dhit; pe = bus.protocol_err; ld = bus.loaddata; f = bus.addr_fault;
    bus.ren = 1'b0; bus.addr = 32'h10;
    @(negedge clk);
    b2 = bus.protocol_err | bus.dhit;
    e = sb.pop_front();
    checks++;
    if (b1 !== 1'b1 || pe !== 1'b1 || ld !== e.ld || f !== e.f || b2 !== 1'b0) begin
      errors++; $display("FAIL addr_change got dhit=%b pe=%b ld=%h f=%b next=%b want dhit=1 pe=1 ld=%h f=%b next=0", b1, pe, ld, f, b2, e.ld, e.f);
    end
  endtask

  task automatic test_back_to_back;
    sb.push_back('{2, 32'hDE22BE44, 1'b0});
    sb.push_back('{5, 32'hDE22BE44, 1'b0});
    sb.push_back('{8, 32'hDE22BE44, 1'b0});
    @(negedge clk);
    bus.ren = 1'b1; bus.wen = 1'b0; bus.addr = 32'h10; bus.byte_ena = 4'hF;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus.dhit) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra got dhit at cycle %0d want none", c);
        end else begin
          e = sb.pop_front();
          if (c !== e.cyc || bus.loaddata !== e.ld || bus.addr_fault !== e.f) begin
            errors++; $display("FAIL b2b_hit got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", c, bus.loaddata, bus.addr_fault, e.cyc, e.ld, e.f);
          end
        end
      end
      if (c == 9) bus.ren = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_missing got %0d hits outstanding want 0", sb.size());
      sb.delete();
    end
    sb.push_back('{1, 32'h0, 1'b0});
    sb.push_back('{3, 32'h0, 1'b0});
    sb.push_back('{5, 32'h0, 1'b0});
    @(negedge clk);
    bus1.ren = 1'b1; bus1.wen = 1'b0; bus1.addr = 32'h0; bus1.byte_ena = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus1.dhit) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_lat1_extra got dhit at cycle %0d want none", c);
        end else begin
          e = sb.pop_front();
          if (c !== e.cyc || bus1.addr_fault !== e.f) begin
            errors++; $display("FAIL b2b_lat1_hit got cyc=%0d f=%b want cyc=%0d f=%b", c, bus1.addr_fault, e.cyc, e.f);
          end
        end
      end
      if (c == 6) bus1.ren = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_lat1_missing got %0d hits outstanding want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid;
    sb.push_back('{2, 32'h0, 1'b0});
    sb.push_back('{2, 32'h0, 1'b0});
    access(1'b0, 1'b1, 32'h20, 32'h0, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL clear_0x20 got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
    @(negedge clk);
    bus.ren = 1'b0; bus.wen = 1'b1; bus.addr = 32'h20; bus.storedata = 32'hFFFFFFFF; bus.byte_ena = 4'hF;
    @(negedge clk);
    b1 = bus.busy;
    #1 rst = 1'b1;
    #1 b2 = bus.busy;
    bus.wen = 1'b0;
    seen = bus.dhit;
    @(negedge clk);
    seen |= bus.dhit;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus.dhit;
    end
    checks++;
    if (b1 !== 1'b1 || b2 !== 1'b0 || seen !== 1'b0) begin
      errors++; $display("FAIL reset_mid got busy_before=%b busy_after=%b dhit=%b want 1 0 0", b1, b2, seen);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    e = sb.pop_front();
    checks++;
    if (hc !== e.cyc || ld !== e.ld || f !== e.f) begin
      errors++; $display("FAIL reset_mid_readback got cyc=%0d ld=%h f=%b want cyc=%0d ld=%h f=%b", hc, ld, f, e.cyc, e.ld, e.f);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_range();
    test_both_high();
    test_abort();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_dmem_responder.md
Name: vector_dmem_responder

Overview:
- Memory-side responder for the vector load/store unit's scalarized data port, the other end of the address scheduler's request stream.
- Accepts one word-wide request (ren/wen, address, store data, byte enables) and answers with a one-cycle dhit plus load data after a fixed latency.
- Backed by a local word-addressed scratchpad.
- Used as the vector unit's data memory in block-level simulation and in small FPGA builds.

Parameters:
- DEPTH_WORDS, 256: scratchpad size in 32-bit words; power of two, minimum 4.
- LATENCY, 2: cycles from request acceptance to dhit; legal range 1..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- ren  input  1  read request; held until dhit
- wen  input  1  write request; held until dhit
- addr  input  32  byte address; addr[1:0] ignored (word access)
- storedata  input  32  write data; lane i = bits [8i+7:8i]
- byte_ena  input  4  per-byte lane enable for both read and write
- dhit  output  1  one-cycle completion pulse
- loaddata  output  32  read data; valid only while dhit=1
- addr_fault  output  1  pulses with dhit when the address is out of range
- protocol_err  output  1  one-cycle pulse on a requester protocol violation
- busy  output  1  high while in WAIT or RESP

Behaviour:
- Reset values: dhit=0, loaddata=0, addr_fault=0, protocol_err=0, busy=0, FSM=IDLE, latency counter=0.
- Scratchpad contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If (ren|wen) is high, latch addr, storedata, byte_ena and the op (write if wen=1, else read).
  - Load counter with LATENCY-1.
  - Go to RESP if LATENCY=1, else to WAIT.
- WAIT:
  - Decrement the counter each cycle; go to RESP when the counter reaches 0 (the counter is 0 as RESP is entered).
  - The latched request is used throughout the access.
  - If ren, wen, addr or byte_ena differ from the latched values, pulse protocol_err for one cycle and stay in WAIT.
  - Abort: if ren=0 and wen=0, return to IDLE with no dhit and no write; protocol_err is not asserted.
- RESP:
  - dhit=1 for exactly one cycle; always return to IDLE next cycle.
  - The cycle after dhit is IDLE, so a still-asserted request is treated as a new request.
  - Timing: a request first sampled in IDLE at edge t produces dhit high during cycle t+LATENCY.
  - Throughput: one access per LATENCY+1 cycles.
- Range check: index = (latched_addr - BASE_ADDR) >> 2. The request is in range iff latched_addr >= BASE_ADDR and index < DEPTH_WORDS.
- Out-of-range request: addr_fault=1 with dhit, no write, loaddata=0.
- Write: at the clock edge ending the RESP cycle, update only the bytes whose byte_ena bit is set. byte_ena=0 completes normally with no change. loaddata=0 for writes.
- Read: loaddata lane i = mem lane i if byte_ena[i]=1, else 8'h00. There is no shifting; lane alignment is the requester's job.
- ren and wen both high on acceptance: the access is performed as a write, and protocol_err pulses in the acceptance cycle.
- X on ren/wen is treated as a bench error; no defined behaviour.
- Reset mid-operation: FSM returns to IDLE immediately and all outputs return to reset values. A pending write is discarded; the scratchpad is unchanged.
- busy=1 in WAIT and RESP, 0 in IDLE.

Test Plan:
1. Defaults (LATENCY=2). Write addr=0x10, storedata=0xDEADBEEF, byte_ena=4'hF at cycle 0 -> dhit in cycle 2 only. Then read 0x10 -> dhit two cycles after acceptance, loaddata=0xDEADBEEF, addr_fault=0.
2. Partial write to 0x10 with byte_ena=4'b0101, data=0x11223344, then full read -> 0xDE22BE44. Read with byte_ena=4'b1000 -> 0xDE000000.
3. Read of addr=BASE_ADDR+DEPTH_WORDS*4 (0x400) -> dhit and addr_fault both pulse at cycle 2, loaddata=0. A following write to 0x400 leaves word 255 unchanged.
4. Request dropped in WAIT (ren deasserted at cycle 1) -> no dhit, busy=0 by cycle 2, protocol_err stays 0. Change addr during WAIT -> protocol_err pulse; completion uses the original address.
5. Back-to-back reads held continuously -> dhit at cycles 2, 5, 8 (period LATENCY+1=3). With LATENCY=1 -> dhit at 1, 3, 5.
6. Assert RST during WAIT of a write to 0x20 (prior value 0x0) -> dhit never pulses, busy=0 asynchronously. A subsequent read of 0x20 returns 0x00000000.
